gteq8_reg: RTL and testbench

- Registered 8-bit magnitude comparator. It reports a >= b, plus the a > b and a == b terms.
- Sits in datapath compare/select logic. Operands are sampled on a valid strobe; results appear one clock later.
- Comparison is built from 2-bit slice comparators combined MSB-first into a greater/equal chain, followed by the output registers.

---
 rtl/gteq8_reg.sv | 80 ++++++++
 tb/tb_gteq8_reg.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/gteq8_reg.sv
// Registered magnitude comparator: a >= b, a > b, a == b, one cycle after in_valid.
// Define GTEQ8_SIGNED_EN to compare two's-complement operands instead of unsigned.
module gteq8_reg #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             agteqb,
  output logic             agtb,
  output logic             aeqb
);

  localparam int NSL = WIDTH / SLICE;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [NSL-1:0]   w_gt_sl;
  logic [NSL-1:0]   w_eq_sl;
  logic             w_gt;
  logic             w_eq;
  logic             w_ge;

  logic             r_out_valid;
  logic             r_agteqb;
  logic             r_agtb;
  logic             r_aeqb;

`ifdef GTEQ8_SIGNED_EN
  // Flipping the sign bit maps two's complement onto an unsigned ordering.
  assign w_a = {~a[WIDTH-1], a[WIDTH-2:0]};
  assign w_b = {~b[WIDTH-1], b[WIDTH-2:0]};
`else
  assign w_a = a;
  assign w_b = b;
`endif

  for (genvar g = 0; g < NSL; g++) begin : g_slice
    assign w_gt_sl[g] = (w_a[g*SLICE +: SLICE] >  w_b[g*SLICE +: SLICE]);
    assign w_eq_sl[g] = (w_a[g*SLICE +: SLICE] == w_b[g*SLICE +: SLICE]);
  end

  // Built LSB-up so each step's w_gt covers all lower slices; the outermost
  // term is the MSB slice, matching gt = gt_msb | (eq_msb & gt_next).
  always_comb begin
    w_gt = 1'b0;
    for (int i = 0; i < NSL; i++) begin
      w_gt = w_gt_sl[i] | (w_eq_sl[i] & w_gt);
    end
  end

  assign w_eq = &w_eq_sl;
  assign w_ge = w_gt | w_eq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_agteqb    <= 1'b0;
      r_agtb      <= 1'b0;
      r_aeqb      <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_agteqb <= w_ge;
        r_agtb   <= w_gt;
        r_aeqb   <= w_eq;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign agteqb    = r_agteqb;
  assign agtb      = r_agtb;
  assign aeqb      = r_aeqb;

endmodule

// File: tb/tb_gteq8_reg.sv
// Scoreboard bench for gteq8_reg: stimulus pushes reference results, a monitor
// pops and compares whenever out_valid is seen, and checks hold/reset behaviour.
module tb_gteq8_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       agteqb;
  logic       agtb;
  logic       aeqb;

  int total = 0;
  int bad   = 0;

  logic [2:0] q_exp[$];
  logic [2:0] held;
  logic [2:0] got;
  logic [2:0] popped;
  logic       edge_rst;
  logic       edge_iv;

  gteq8_reg #(.WIDTH(8), .SLICE(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .agteqb   (agteqb),
    .agtb     (agtb),
    .aeqb     (aeqb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer comparison, signed when the option is compiled in.
  function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
`ifdef GTEQ8_SIGNED_EN
    sx = $signed(x);
    sy = $signed(y);
`else
    sx = int'(x);
    sy = int'(y);
`endif
    return {sx >= sy, sx > sy, sx == sy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    q_exp.push_back(ref_cmp(x, y));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    edge_rst = rst_n;
    edge_iv  = in_valid;
    #1;
    if (!edge_rst || !rst_n) begin
      q_exp.delete();
      held = 3'b000;
    end else begin
      got = {agteqb, agtb, aeqb};
      chk("out_valid", 32'(out_valid), 32'(edge_iv));
      if (out_valid) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_result", 32'(1), 32'(0));
        end else begin
          popped = q_exp.pop_front();
          chk("result_ge_gt_eq", 32'(got), 32'(popped));
          held = popped;
        end
      end else begin
        chk("hold_ge_gt_eq", 32'(got), 32'(held));
      end
      chk("inv_ge_is_gt_or_eq", 32'(agteqb), 32'(agtb | aeqb));
      chk("inv_gt_eq_exclusive", 32'(agtb & aeqb), 32'(0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] va[$];
    logic [7:0] vb[$];
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    held     = 3'b000;
    #17;
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_outputs", 32'({agteqb, agtb, aeqb}), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(8'hAA, 8'hAA);

    va = '{8'hCC, 8'h0C, 8'h57, 8'h03, 8'h69, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'hFF};
    vb = '{8'hBC, 8'h0D, 8'h56, 8'h04, 8'h68, 8'hDF, 8'h02, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h00};
    for (int i = 0; i < va.size(); i++) send(va[i], vb[i]);

    // Hold: operands that would flip the result must not disturb held outputs.
    send(8'hCC, 8'hBC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'h00;
      b = 8'hFF;
    end

    // Async reset between edges after a completed capture.
    send(8'h57, 8'h56);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'(0));
    chk("async_rst_outputs", 32'({agteqb, agtb, aeqb}), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h0C, 8'h0D);

    // In-flight capture discarded by a reset asserted before its edge.
    send(8'hFF, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("inflight_rst_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 5) == 0) begin
          logic [7:0] r;
          r = 8'($urandom);
          send(r, r);
        end else begin
          send(8'($urandom), 8'($urandom));
        end
      end else begin
        idle(1);
      end
    end

    idle(3);
    chk("scoreboard_drained", 32'(q_exp.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
